// File: rtl/spi_mnrch_gen.sv
// SPI monarch, mode 3 (CPOL=1, CPHA=1), parametrised word width, SCLK divider and one-hot selects.
// Latency: done rises H/2 + 2*H*DATA_W clocks after the accepting wrt edge (H = 2**DIV_LOG2).
// Backpressure: wrt is only accepted while busy==0; SPI_MNRCH_BURST_EN adds hold to keep SS_n across words.
module spi_mnrch_gen #(
    parameter int DATA_W   = 16,
    parameter int DIV_LOG2 = 4,
    parameter int NUM_SS   = 1,
    localparam int SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrt,
    input  logic [DATA_W-1:0] wt_data,
    input  logic [SS_W-1:0]   ss_sel,
`ifdef SPI_MNRCH_BURST_EN
    input  logic              hold,
`endif
    input  logic              MISO,
    output logic              SCLK,
    output logic              MOSI,
    output logic [NUM_SS-1:0] SS_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int DIV_W = DIV_LOG2 + 1;

    // Load value sits H/2 increments short of all-ones, which gives the front porch.
    localparam logic [DIV_W-1:0] DIV_LOAD = {2'b10, {(DIV_W-2){1'b1}}};
    localparam logic [DIV_W-1:0] DIV_FALL = {DIV_W{1'b1}};
    localparam logic [DIV_W-1:0] DIV_RISE = {1'b0, {(DIV_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FRONT,
        ST_XFER,
        ST_BACK
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DATA_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                miso_smpl_q, miso_smpl_d;
    logic [NUM_SS-1:0]   ss_n_q, ss_n_d;
    logic                done_q, done_d;
    logic [NUM_SS-1:0]   sel_onehot;
    logic                fall_imm;
    logic                rise_imm;
    logic                release_ss;

`ifdef SPI_MNRCH_BURST_EN
    logic                hold_q, hold_d;

    assign release_ss = ~hold_q;
`else
    assign release_ss = 1'b1;
`endif

    assign fall_imm = (div_q == DIV_FALL);
    assign rise_imm = (div_q == DIV_RISE);

    // Out-of-range ss_sel decodes to no select at all; the transfer still runs.
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < NUM_SS; i++) begin
            sel_onehot[i] = (ss_sel == SS_W'(i));
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q + DIV_W'(1);
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        miso_smpl_d = miso_smpl_q;
        ss_n_d      = ss_n_q;
        done_d      = done_q;
`ifdef SPI_MNRCH_BURST_EN
        hold_d      = hold_q;
`endif
        case (state_q)
            ST_IDLE: begin
                div_d = DIV_LOAD;
                if (wrt) begin
                    div_d   = DIV_LOAD + DIV_W'(1);
                    sr_d    = wt_data;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    ss_n_d  = ~sel_onehot;
                    state_d = ST_FRONT;
`ifdef SPI_MNRCH_BURST_EN
                    hold_d  = hold;
`endif
                end
            end
            ST_FRONT: begin
                if (fall_imm) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (rise_imm) begin
                    miso_smpl_d = MISO;
                end
                if (fall_imm) begin
                    sr_d  = {sr_q[DATA_W-2:0], miso_smpl_q};
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_BACK;
                end
            end
            ST_BACK: begin
                if (rise_imm) begin
                    miso_smpl_d = MISO;
                end
                // Final shift completes the word; reload keeps SCLK high with no extra edge.
                if (fall_imm) begin
                    sr_d    = {sr_q[DATA_W-2:0], miso_smpl_q};
                    done_d  = 1'b1;
                    div_d   = DIV_LOAD;
                    state_d = ST_IDLE;
                    if (release_ss) begin
                        ss_n_d = '1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            div_q       <= DIV_LOAD;
            sr_q        <= '1;
            cnt_q       <= '0;
            miso_smpl_q <= 1'b1;
            ss_n_q      <= '1;
            done_q      <= 1'b0;
`ifdef SPI_MNRCH_BURST_EN
            hold_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            miso_smpl_q <= miso_smpl_d;
            ss_n_q      <= ss_n_d;
            done_q      <= done_d;
`ifdef SPI_MNRCH_BURST_EN
            hold_q      <= hold_d;
`endif
        end
    end

    assign SCLK    = div_q[DIV_W-1];
    assign MOSI    = sr_q[DATA_W-1];
    assign SS_n    = ss_n_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign rd_data = sr_q;

endmodule
